timer_mmss_counter: RTL and testbench
=====================================

Name: timer_mmss_counter

Overview:
- Datapath stage directly downstream of TimerStateMachine.
- Consumes enableCounter / forward / resetTimer and the operator set pulses, and holds the MM:SS timer value as four BCD digits.
- Drives the VGA text/digit renderer and raises an expiry flag on countdown reaching 00:00.
- Contains its own 1 Hz prescaler derived from the system clock.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick; minimum 2; simulation uses 4.
- MAX_MIN, 59: highest minutes value; wrap and load limit.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enableCounter  in  1  count on ticks while high
- forward  in  1  1 = count up, 0 = count down
- resetTimer  in  1  synchronous clear of value and prescaler
- segDemand  in  1  one-cycle pulse: +1 second (set mode)
- minDemand  in  1  one-cycle pulse: +1 minute (set mode)
- secUnits  out  4  BCD 0-9
- secTens  out  4  BCD 0-5
- minUnits  out  4  BCD 0-9
- minTens  out  4  BCD 0-5
- tick  out  1  one-cycle pulse when prescaler wraps
- isZero  out  1  combinational: value == 00:00
- timeUp  out  1  one-cycle pulse on the down-count step that lands on 00:00

Behaviour:
- Reset (rst_n=0, async): all digits 0, prescaler 0; tick, timeUp = 0; isZero = 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while enableCounter=1.
  - tick fires in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 while enableCounter=0, so the first tick comes TICK_DIV cycles after enable rises.
- Priority per cycle (highest first):
  1. resetTimer
  2. set pulses (only when enableCounter=0)
  3. tick step
- resetTimer=1: digits → 00:00 and prescaler → 0 next edge; overrides simultaneous tick or set pulses; timeUp suppressed.
- segDemand (enableCounter=0): seconds +1 mod 60; no carry into minutes.
- minDemand (enableCounter=0): minutes +1 mod (MAX_MIN+1).
- Both set pulses in the same cycle: both applied.
- Set pulses are ignored while enableCounter=1.
- Tick step, forward=1: MM:SS +1 s, BCD carry chain su→st→mu→mt; MAX_MIN:59 wraps to 00:00; no timeUp.
- Tick step, forward=0:
  - MM:SS −1 s with borrow chain.
  - Transition 00:01→00:00 asserts timeUp for exactly that cycle (registered, aligned with the value update).
  - At 00:00 the value holds (no underflow) and timeUp stays 0.
- Digit updates take effect on the clock edge after the qualifying tick/pulse cycle; latency 1.
- Digits are never outside legal BCD range; illegal states are unreachable.
- enableCounter dropping mid-second: prescaler clears and the partial second is discarded.

Optional Feature:
- Macro TIMER_ALARM_EN.
- Defined: extra output alarm (1 bit). Set on the same edge as timeUp and held high until resetTimer=1 or rst_n=0. A set pulse or forward=1 counting does not clear it.
- Undefined: no alarm port; timeUp pulse only.

Decomposition:
- Package timer_pkg:
  - bcd_t (4-bit digit type)
  - SEC_TENS_MAX=5, UNITS_MAX=9, MIN_TENS_MAX derived from MAX_MIN
  - default TICK_DIV
- Sub-module bcd_digit_counter, instantiated four times:
  - Parameter: digit modulo.
  - Inputs: inc, dec, clr.
  - Outputs: carry on wrap-up, borrow on wrap-down.
  - Minutes-units wrap depends on the tens digit, so the top-level overrides it at MAX_MIN.

Test Plan:
- Reset: TICK_DIV=4; assert rst_n=0 mid-count at 03:27 → outputs 00:00 immediately (async), isZero=1, tick=0.
- Set mode: enableCounter=0; 3×segDemand and 2×minDemand → 02:03. Then 60 further segDemand → seconds wrap, 02:03 again, minutes unchanged.
- Up count: load 00:58, enableCounter=1, forward=1 → tick at cycles 4, 8, 12, with values 00:59, 01:00, 01:01. Preload 59:59, one tick → 00:00, timeUp=0.
- Down count: load 00:02, forward=0 → 00:01 then 00:00 with timeUp high exactly 1 cycle. Further ticks hold 00:00 with timeUp=0. With TIMER_ALARM_EN, alarm stays 1 until resetTimer.
- Priority: resetTimer=1 in the same cycle as tick and segDemand at 10:10 → 00:00, prescaler 0, no timeUp. segDemand while enableCounter=1 → value unchanged.
- Pause: drop enableCounter after 2 of 4 prescaler cycles, then re-raise it → next tick exactly 4 cycles after re-enable; value unchanged during the pause.

Source files
------------

// File: rtl/timer_mmss_counter_pkg.sv
// Shared types and constants for the MM:SS timer datapath.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned UNITS_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MAX_MIN_DEF  = 59;
  localparam int unsigned TICK_DIV_DEF = 100_000_000;

  // Highest legal minutes-tens digit for a given minutes limit.
  function automatic int unsigned min_tens_of(input int unsigned max_min);
    return max_min / 10;
  endfunction

  localparam int unsigned MIN_TENS_MAX = min_tens_of(MAX_MIN_DEF);

  // What the digit chain does this cycle.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_SET,
    STEP_UP,
    STEP_DOWN
  } step_e;

endpackage

// File: rtl/timer_mmss_counter_bcd_digit_counter.sv
// One BCD digit with wrap-around in both directions.
// carry/borrow are combinational and flag the wrap happening this cycle.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter int unsigned MODULO = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  input  logic force_wrap,
  output bcd_t value,
  output logic carry,
  output logic borrow
);

  localparam bcd_t TOP = bcd_t'(MODULO - 1);

  bcd_t val_q, val_d;

  // Next digit value plus wrap flags; clear beats inc beats dec.
  always_comb begin
    val_d  = val_q;
    carry  = 1'b0;
    borrow = 1'b0;
    if (clr) begin
      val_d = '0;
    end else if (inc) begin
      if (val_q == TOP || force_wrap) begin
        val_d = '0;
        carry = 1'b1;
      end else begin
        val_d = val_q + 4'd1;
      end
    end else if (dec) begin
      if (val_q == '0) begin
        val_d  = TOP;
        borrow = 1'b1;
      end else begin
        val_d = val_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign value = val_q;

endmodule

// File: rtl/timer_mmss_counter.sv
// MM:SS timer value with its own one-second prescaler.
// Optional macro TIMER_ALARM_EN adds a sticky 'alarm' output set on expiry.
module timer_mmss_counter
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned MAX_MIN  = MAX_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enableCounter,
  input  logic       forward,
  input  logic       resetTimer,
  input  logic       segDemand,
  input  logic       minDemand,
  output logic [3:0] secUnits,
  output logic [3:0] secTens,
  output logic [3:0] minUnits,
  output logic [3:0] minTens,
  output logic       tick,
  output logic       isZero,
  output logic       timeUp
`ifdef TIMER_ALARM_EN
  ,
  output logic       alarm
`endif
);

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam int unsigned   MT_MAX    = min_tens_of(MAX_MIN);
  localparam bcd_t          MT_AT_MAX = bcd_t'(MT_MAX);
  localparam bcd_t          MU_AT_MAX = bcd_t'(MAX_MIN % 10);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          time_up_q, time_up_d;
  step_e         step;
  logic          su_inc, su_dec, su_carry, su_borrow;
  logic          st_inc, st_dec, st_carry, st_borrow;
  logic          mu_inc, mu_dec, mu_carry, mu_borrow, mu_wrap;
  logic          mt_inc, mt_dec, unused_mt_carry, unused_mt_borrow;

  // Prescaler runs only while enabled; dropping enable discards the partial second.
  always_comb begin
    cnt_d = cnt_q;
    if (resetTimer || !enableCounter) cnt_d = '0;
    else if (cnt_q == CNT_LAST)       cnt_d = '0;
    else                              cnt_d = cnt_q + 1'b1;
  end

  assign tick   = enableCounter && (cnt_q == CNT_LAST);
  assign isZero = ({minTens, minUnits, secTens, secUnits} == '0);

  // Pick this cycle's action: clear > set pulses (paused only) > tick step.
  always_comb begin
    step = STEP_NONE;
    if (resetTimer) begin
      step = STEP_NONE;
    end else if (!enableCounter) begin
      if (segDemand || minDemand) step = STEP_SET;
    end else if (tick) begin
      if (forward)      step = STEP_UP;
      else if (!isZero) step = STEP_DOWN;
    end
  end

  // Carry chain su->st->mu->mt; seconds set never carries into minutes.
  assign su_inc  = (step == STEP_SET && segDemand) || (step == STEP_UP);
  assign su_dec  = (step == STEP_DOWN);
  assign st_inc  = su_carry;
  assign st_dec  = su_borrow;
  assign mu_inc  = (step == STEP_SET && minDemand) || (step == STEP_UP && st_carry);
  assign mu_dec  = st_borrow;
  assign mu_wrap = (minTens == MT_AT_MAX) && (minUnits == MU_AT_MAX);
  assign mt_inc  = mu_carry;
  assign mt_dec  = mu_borrow;

  // Expiry pulse aligned with the edge that lands on 00:00.
  always_comb begin
    time_up_d = (step == STEP_DOWN) && ({minTens, minUnits, secTens, secUnits} == 16'h0001);
  end

  // Prescaler and expiry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      time_up_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      time_up_q <= time_up_d;
    end
  end

  assign timeUp = time_up_q;

`ifdef TIMER_ALARM_EN
  logic alarm_q, alarm_d;

  // Sticky alarm: only a timer clear or reset drops it.
  always_comb begin
    alarm_d = resetTimer ? 1'b0 : (alarm_q | time_up_d);
  end

  // Alarm register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

  bcd_digit_counter #(.MODULO(UNITS_MAX + 1)) u_sec_units (
    .clk(clk), .rst_n(rst_n), .clr(resetTimer), .inc(su_inc), .dec(su_dec),
    .force_wrap(1'b0), .value(secUnits), .carry(su_carry), .borrow(su_borrow)
  );

  bcd_digit_counter #(.MODULO(SEC_TENS_MAX + 1)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(resetTimer), .inc(st_inc), .dec(st_dec),
    .force_wrap(1'b0), .value(secTens), .carry(st_carry), .borrow(st_borrow)
  );

  // Minutes units wraps early when the tens digit sits at its limit.
  bcd_digit_counter #(.MODULO(UNITS_MAX + 1)) u_min_units (
    .clk(clk), .rst_n(rst_n), .clr(resetTimer), .inc(mu_inc), .dec(mu_dec),
    .force_wrap(mu_wrap), .value(minUnits), .carry(mu_carry), .borrow(mu_borrow)
  );

  bcd_digit_counter #(.MODULO(MT_MAX + 1)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(resetTimer), .inc(mt_inc), .dec(mt_dec),
    .force_wrap(1'b0), .value(minTens), .carry(unused_mt_carry), .borrow(unused_mt_borrow)
  );

endmodule

// File: tb/tb_timer_mmss_counter.sv
// Directed bench for timer_mmss_counter with TICK_DIV=4.
module tb_timer_mmss_counter;

  logic       clk = 1'b0;
  logic       rst_n, enableCounter, forward, resetTimer, segDemand, minDemand;
  logic [3:0] secUnits, secTens, minUnits, minTens;
  logic       tick, isZero, timeUp;
`ifdef TIMER_ALARM_EN
  logic       alarm;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  timer_mmss_counter #(.TICK_DIV(4), .MAX_MIN(59)) dut (
    .clk(clk), .rst_n(rst_n), .enableCounter(enableCounter), .forward(forward),
    .resetTimer(resetTimer), .segDemand(segDemand), .minDemand(minDemand),
    .secUnits(secUnits), .secTens(secTens), .minUnits(minUnits), .minTens(minTens),
    .tick(tick), .isZero(isZero), .timeUp(timeUp)
`ifdef TIMER_ALARM_EN
    , .alarm(alarm)
`endif
  );

  function automatic logic [15:0] shown();
    return {minTens, minUnits, secTens, secUnits};
  endfunction

  // Stimulus helpers; all start and end just after a falling edge.
  task automatic pulse_sec(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      segDemand = 1'b1; @(negedge clk);
      segDemand = 1'b0; @(negedge clk);
    end
  endtask

  task automatic pulse_min(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      minDemand = 1'b1; @(negedge clk);
      minDemand = 1'b0; @(negedge clk);
    end
  endtask

  task automatic clear_timer();
    resetTimer = 1'b1; @(negedge clk);
    resetTimer = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (isZero !== 1'b1) begin n_bad++; $display("FAIL reset_iszero: got %b expected 1", isZero); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL reset_timeup: got %b expected 0", timeUp); end
    rst_n = 1'b1; @(negedge clk);
    pulse_min(3); pulse_sec(27);
    n_cmp++; if (shown() !== 16'h0327) begin n_bad++; $display("FAIL reset_preload: got %h expected %h", shown(), 16'h0327); end
    enableCounter = 1'b1; forward = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL async_reset_value: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (isZero !== 1'b1) begin n_bad++; $display("FAIL async_reset_iszero: got %b expected 1", isZero); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL async_reset_tick: got %b expected 0", tick); end
`ifdef TIMER_ALARM_EN
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
`endif
    enableCounter = 1'b0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_set();
    clear_timer();
    pulse_sec(3); pulse_min(2);
    n_cmp++; if (shown() !== 16'h0203) begin n_bad++; $display("FAIL set_load: got %h expected %h", shown(), 16'h0203); end
    pulse_sec(60);
    n_cmp++; if (shown() !== 16'h0203) begin n_bad++; $display("FAIL set_sec_wrap: got %h expected %h", shown(), 16'h0203); end
    pulse_min(58);
    n_cmp++; if (shown() !== 16'h0003) begin n_bad++; $display("FAIL set_min_wrap: got %h expected %h", shown(), 16'h0003); end
  endtask

  task automatic test_back_to_back();
    clear_timer();
    segDemand = 1'b1; minDemand = 1'b1; @(negedge clk);
    n_cmp++; if (shown() !== 16'h0101) begin n_bad++; $display("FAIL both_pulses: got %h expected %h", shown(), 16'h0101); end
    @(negedge clk);
    n_cmp++; if (shown() !== 16'h0202) begin n_bad++; $display("FAIL b2b_pulses: got %h expected %h", shown(), 16'h0202); end
    segDemand = 1'b0; minDemand = 1'b0; @(negedge clk);
    n_cmp++; if (shown() !== 16'h0202) begin n_bad++; $display("FAIL b2b_hold: got %h expected %h", shown(), 16'h0202); end
  endtask

  task automatic test_up_count();
    logic        exp_tick;
    logic [15:0] exp_val;
    clear_timer();
    pulse_sec(58);
    enableCounter = 1'b1; forward = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_tick = (c % 4 == 3);
      exp_val  = (c < 4) ? 16'h0058 : (c < 8) ? 16'h0059 : (c < 12) ? 16'h0100 : 16'h0101;
      n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL up_tick c=%0d: got %b expected %b", c, tick, exp_tick); end
      n_cmp++; if (shown() !== exp_val) begin n_bad++; $display("FAIL up_value c=%0d: got %h expected %h", c, shown(), exp_val); end
    end
    enableCounter = 1'b0; @(negedge clk);
    clear_timer();
    pulse_min(59); pulse_sec(59);
    n_cmp++; if (shown() !== 16'h5959) begin n_bad++; $display("FAIL up_preload: got %h expected %h", shown(), 16'h5959); end
    enableCounter = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL up_full_wrap: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL up_no_timeup: got %b expected 0", timeUp); end
    n_cmp++; if (isZero !== 1'b1) begin n_bad++; $display("FAIL up_wrap_iszero: got %b expected 1", isZero); end
    enableCounter = 1'b0; @(negedge clk);
  endtask

  task automatic test_down_count();
    clear_timer();
    pulse_min(1);
    enableCounter = 1'b1; forward = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (shown() !== 16'h0059) begin n_bad++; $display("FAIL down_borrow: got %h expected %h", shown(), 16'h0059); end
    enableCounter = 1'b0; @(negedge clk);
    clear_timer();
    pulse_sec(2);
    enableCounter = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (shown() !== 16'h0001) begin n_bad++; $display("FAIL down_first: got %h expected %h", shown(), 16'h0001); end
    n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL down_early_timeup: got %b expected 0", timeUp); end
    repeat (4) @(negedge clk);
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL down_zero: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (timeUp !== 1'b1) begin n_bad++; $display("FAIL down_timeup: got %b expected 1", timeUp); end
    n_cmp++; if (isZero !== 1'b1) begin n_bad++; $display("FAIL down_iszero: got %b expected 1", isZero); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL down_hold_timeup c=%0d: got %b expected 0", c, timeUp); end
      n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL down_hold c=%0d: got %h expected %h", c, shown(), 16'h0000); end
`ifdef TIMER_ALARM_EN
      n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_hold c=%0d: got %b expected 1", c, alarm); end
`endif
    end
    enableCounter = 1'b0; @(negedge clk);
    pulse_sec(1);
    n_cmp++; if (shown() !== 16'h0001) begin n_bad++; $display("FAIL down_after_set: got %h expected %h", shown(), 16'h0001); end
`ifdef TIMER_ALARM_EN
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_after_set: got %b expected 1", alarm); end
    clear_timer(); @(negedge clk);
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_cleared: got %b expected 0", alarm); end
`endif
  endtask

  task automatic test_priority();
    clear_timer();
    pulse_min(10); pulse_sec(10);
    enableCounter = 1'b1; forward = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL prio_tick: got %b expected 1", tick); end
    resetTimer = 1'b1; segDemand = 1'b1; minDemand = 1'b1;
    @(negedge clk);
    resetTimer = 1'b0; segDemand = 1'b0; minDemand = 1'b0;
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL prio_clear: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL prio_timeup: got %b expected 0", timeUp); end
    segDemand = 1'b1; @(negedge clk); segDemand = 1'b0;
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL prio_set_ignored: got %h expected %h", shown(), 16'h0000); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL prio_presc_1: got %b expected 0", tick); end
    @(negedge clk);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL prio_presc_2: got %b expected 0", tick); end
    @(negedge clk);
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL prio_presc_3: got %b expected 1", tick); end
    enableCounter = 1'b0; @(negedge clk);
    clear_timer();
    pulse_sec(1);
    enableCounter = 1'b1; forward = 1'b0;
    repeat (3) @(negedge clk);
    resetTimer = 1'b1; @(negedge clk); resetTimer = 1'b0;
    n_cmp++; if (timeUp !== 1'b0) begin n_bad++; $display("FAIL prio_down_timeup: got %b expected 0", timeUp); end
    n_cmp++; if (shown() !== 16'h0000) begin n_bad++; $display("FAIL prio_down_value: got %h expected %h", shown(), 16'h0000); end
`ifdef TIMER_ALARM_EN
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL prio_alarm: got %b expected 0", alarm); end
`endif
    enableCounter = 1'b0; @(negedge clk);
  endtask

  task automatic test_pause();
    logic        exp_tick;
    logic [15:0] exp_val;
    clear_timer();
    pulse_sec(5);
    enableCounter = 1'b1; forward = 1'b1;
    repeat (2) @(negedge clk);
    enableCounter = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (shown() !== 16'h0005) begin n_bad++; $display("FAIL pause_hold c=%0d: got %h expected %h", c, shown(), 16'h0005); end
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL pause_tick c=%0d: got %b expected 0", c, tick); end
    end
    enableCounter = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_tick = (c == 3);
      exp_val  = (c < 4) ? 16'h0005 : 16'h0006;
      n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL resume_tick c=%0d: got %b expected %b", c, tick, exp_tick); end
      n_cmp++; if (shown() !== exp_val) begin n_bad++; $display("FAIL resume_value c=%0d: got %h expected %h", c, shown(), exp_val); end
    end
    enableCounter = 1'b0; @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enableCounter = 1'b0; forward = 1'b1;
    resetTimer = 1'b0; segDemand = 1'b0; minDemand = 1'b0;
    test_reset();
    test_set();
    test_back_to_back();
    test_up_count();
    test_down_count();
    test_priority();
    test_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
